// File: rtl/axi_timer_pkg.sv
// Shared register offsets, bit indices and response codes for the AXI4-Lite timer.
package axi_timer_pkg;

  localparam logic [11:0] TMR_CTRL     = 12'h000;
  localparam logic [11:0] TMR_COUNT_LO = 12'h004;
  localparam logic [11:0] TMR_COUNT_HI = 12'h008;
  localparam logic [11:0] TMR_PRESCALE = 12'h00C;
  localparam logic [11:0] TMR_CMP_LO   = 12'h010;
  localparam logic [11:0] TMR_CMP_HI   = 12'h014;
  localparam logic [11:0] TMR_STATUS   = 12'h018;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_CLR_BIT     = 1;
  localparam int unsigned STATUS_MATCH_BIT = 0;
  localparam int unsigned STATUS_IE_BIT    = 1;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  // Byte-lane merge of a write into an existing 32-bit value.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Offsets outside the 8-word window, plus the last word, have no register.
  function automatic logic reg_unmapped(input logic [11:0] off);
    return (off[11:5] != 7'd0) || (off[4:2] == 3'b111);
  endfunction

endpackage

// File: rtl/timer_core.sv
// Prescaled 64-bit free-running counter with load/clear and optional compare.
// Compare ports exist only when TIMER_CMP_EN is defined.
module timer_core #(
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   load_lo,
  input  logic                   load_hi,
  input  logic [31:0]            load_data,
  input  logic [PRESC_WIDTH-1:0] prescale,
  output logic [63:0]            count
`ifdef TIMER_CMP_EN
  ,
  input  logic [63:0]            cmp,
  output logic                   match_hit_c
`endif
);

  logic [PRESC_WIDTH-1:0] pcnt;
  logic                   tick_c;

  // >= so a PRESCALE lowered below the running count cannot stall the counter.
  assign tick_c = en && (pcnt >= prescale);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
      pcnt  <= '0;
    end else if (clr) begin
      count <= '0;
      pcnt  <= '0;
    end else begin
      if (en) pcnt <= tick_c ? '0 : pcnt + PRESC_WIDTH'(1);
      if (load_lo)      count[31:0]  <= load_data;
      else if (load_hi) count[63:32] <= load_data;
      else if (tick_c)  count        <= count + 64'd1;
    end
  end

`ifdef TIMER_CMP_EN
  assign match_hit_c = en && (count == cmp);
`endif

endmodule

// File: rtl/axi_lite_timer.sv
// AXI4-Lite subordinate wrapping timer_core: channel handshakes and register file.
// Define TIMER_CMP_EN to add the CMP_LO/CMP_HI/STATUS registers and the irq output.
module axi_lite_timer
  import axi_timer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  irq
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axi_lite_timer: only DATA_WIDTH=32 is supported");
  end

  logic                   aw_held, w_held, aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic [9:0]             aw_off_q;
  logic [31:0]            w_data_q;
  logic [3:0]             w_strb_q;
  logic                   aw_hs_c, w_hs_c, ar_hs_c, commit_c, b_done_c;
  logic [11:0]            wr_off, rd_off;
  logic                   wr_err_c, rd_err_c;
  logic [31:0]            rd_data_c;
  logic                   ctrl_en;
  logic [PRESC_WIDTH-1:0] prescale;
  logic [31:0]            snapshot;
  logic [63:0]            count;
  logic                   ctrl_wr_c, en_eff_c, clr_c, load_lo_c, load_hi_c;
  logic [31:0]            load_data_c;
  logic                   unused_ok;
`ifdef TIMER_CMP_EN
  logic [31:0]            cmp_lo, cmp_hi;
  logic                   match, ie, match_hit_c, status_wr_c, match_n, ie_n;
`endif

  assign unused_ok = ^{awprot, arprot, awaddr[ADDR_WIDTH-1:12], awaddr[1:0],
                       araddr[ADDR_WIDTH-1:12], araddr[1:0]};

  assign aw_hs_c  = awvalid && awready;
  assign w_hs_c   = wvalid && wready;
  assign ar_hs_c  = arvalid && arready;
  assign commit_c = aw_held && w_held && !bvalid;
  assign b_done_c = bvalid && bready;
  assign wr_off   = {aw_off_q, 2'b00};
  assign rd_off   = {araddr[11:2], 2'b00};
  assign wr_err_c = reg_unmapped(wr_off);

  // Write-channel next state; readies are registered from these.
  always_comb begin
    aw_held_n = aw_held;
    w_held_n  = w_held;
    bvalid_n  = bvalid;
    if (aw_hs_c) aw_held_n = 1'b1;
    if (w_hs_c)  w_held_n  = 1'b1;
    if (commit_c) bvalid_n = 1'b1;
    if (b_done_c) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
      bvalid_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid   <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bresp    <= RESP_OKAY;
      aw_off_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      bvalid  <= bvalid_n;
      awready <= !aw_held_n && !bvalid_n;
      wready  <= !w_held_n && !bvalid_n;
      if (aw_hs_c) aw_off_q <= awaddr[11:2];
      if (w_hs_c) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit_c) bresp <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // A committing CTRL write takes effect on the counter at the same edge.
  assign ctrl_wr_c   = commit_c && (wr_off == TMR_CTRL) && w_strb_q[0];
  assign en_eff_c    = ctrl_wr_c ? w_data_q[CTRL_EN_BIT] : ctrl_en;
  assign clr_c       = ctrl_wr_c && w_data_q[CTRL_CLR_BIT];
  assign load_lo_c   = commit_c && (wr_off == TMR_COUNT_LO);
  assign load_hi_c   = commit_c && (wr_off == TMR_COUNT_HI);
  assign load_data_c = apply_strb(load_hi_c ? count[63:32] : count[31:0], w_data_q, w_strb_q);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ctrl_en  <= 1'b0;
      prescale <= '0;
    end else begin
      ctrl_en <= en_eff_c;
      if (commit_c && (wr_off == TMR_PRESCALE))
        prescale <= PRESC_WIDTH'(apply_strb(32'(prescale), w_data_q, w_strb_q));
    end
  end

`ifdef TIMER_CMP_EN
  // Sticky match: a new hit in the same cycle as a W1C keeps MATCH set.
  assign status_wr_c = commit_c && (wr_off == TMR_STATUS) && w_strb_q[0];
  assign match_n     = match_hit_c || (match && !(status_wr_c && w_data_q[STATUS_MATCH_BIT]));
  assign ie_n        = status_wr_c ? w_data_q[STATUS_IE_BIT] : ie;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cmp_lo <= '1;
      cmp_hi <= '1;
      match  <= 1'b0;
      ie     <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (commit_c && (wr_off == TMR_CMP_LO)) cmp_lo <= apply_strb(cmp_lo, w_data_q, w_strb_q);
      if (commit_c && (wr_off == TMR_CMP_HI)) cmp_hi <= apply_strb(cmp_hi, w_data_q, w_strb_q);
      match <= match_n;
      ie    <= ie_n;
      irq   <= match_n && ie_n;
    end
  end
`else
  assign irq = 1'b0;
`endif

  timer_core #(.PRESC_WIDTH(PRESC_WIDTH)) u_core (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en_eff_c),
    .clr        (clr_c),
    .load_lo    (load_lo_c),
    .load_hi    (load_hi_c),
    .load_data  (load_data_c),
    .prescale   (prescale),
    .count      (count)
`ifdef TIMER_CMP_EN
    ,
    .cmp        ({cmp_hi, cmp_lo}),
    .match_hit_c(match_hit_c)
`endif
  );

  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b0;
    case (rd_off)
      TMR_CTRL:     rd_data_c[CTRL_EN_BIT] = ctrl_en;
      TMR_COUNT_LO: rd_data_c = count[31:0];
      TMR_COUNT_HI: rd_data_c = snapshot;
      TMR_PRESCALE: rd_data_c = 32'(prescale);
`ifdef TIMER_CMP_EN
      TMR_CMP_LO:   rd_data_c = cmp_lo;
      TMR_CMP_HI:   rd_data_c = cmp_hi;
      TMR_STATUS: begin
        rd_data_c[STATUS_MATCH_BIT] = match;
        rd_data_c[STATUS_IE_BIT]    = ie;
      end
`else
      TMR_CMP_LO, TMR_CMP_HI, TMR_STATUS: rd_data_c = '0;
`endif
      default:      rd_err_c = 1'b1;
    endcase
  end

  assign rvalid_n = ar_hs_c ? 1'b1 : ((rvalid && rready) ? 1'b0 : rvalid);

  // COUNT_LO reads latch the live upper word so a following HI read is coherent.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rvalid   <= 1'b0;
      arready  <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      snapshot <= '0;
    end else begin
      rvalid  <= rvalid_n;
      arready <= !rvalid_n;
      if (ar_hs_c) begin
        rdata <= rd_data_c;
        rresp <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
        if (rd_off == TMR_COUNT_LO) snapshot <= count[63:32];
      end
    end
  end

endmodule
